// File: rtl/voice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : voice_sequencer
// Brief    : Frames the shared voice generator over three voices per sample
//            tick and sums their samples into one signed mix word.
//            Optional WAIT timeout enabled by defining VSEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module voice_sequencer #(
    parameter int NUM_VOICES     = 3
`ifdef VSEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      sample_tick_i,
    input  logic [16*NUM_VOICES-1:0]  freq_words_i,
    input  logic [12*NUM_VOICES-1:0]  pw_words_i,
    input  logic [4*NUM_VOICES-1:0]   wave_sels_i,
    input  logic [NUM_VOICES-1:0]     sync_i,
    input  logic [NUM_VOICES-1:0]     ring_mod_i,
    input  logic [NUM_VOICES-1:0]     voice_en_i,
    output logic                      mv_start_o,
    output logic [1:0]                mv_voice_o,
    output logic [15:0]               mv_freq_o,
    output logic [11:0]               mv_pw_o,
    output logic [3:0]                mv_wave_sel_o,
    output logic                      mv_sync_o,
    output logic                      mv_ring_o,
    input  logic                      mv_ready_i,
    input  logic [9:0]                mv_wave_i,
    output logic [11:0]               mix_o,
    output logic                      mix_valid_o,
    output logic                      busy_o,
`ifdef VSEQ_TIMEOUT_EN
    output logic                      timeout_o,
`endif
    output logic                      overrun_o
);

    localparam logic [1:0] LAST_VOICE = 2'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;
    logic [1:0]  idx_q;
    logic [11:0] acc_q;

    // Voice 0 config is latched straight into the mv_* registers, so the
    // snapshot only needs to hold voices 1 and up.
    logic [16*NUM_VOICES-1:16] freq_q;
    logic [12*NUM_VOICES-1:12] pw_q;
    logic [4*NUM_VOICES-1:4]   wave_q;
    logic [NUM_VOICES-1:1]     sync_q;
    logic [NUM_VOICES-1:1]     ring_q;
    logic [NUM_VOICES-1:0]     en_q;

    logic [1:0]  nidx_d;
    logic [11:0] contrib_d;
    logic        advance_d;

    assign nidx_d    = idx_q + 2'd1;
    assign contrib_d = (mv_ready_i && en_q[idx_q]) ? {{2{mv_wave_i[9]}}, mv_wave_i} : 12'd0;
    assign overrun_o = sample_tick_i && (state_q != S_IDLE);

`ifdef VSEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             expire_d;

    assign expire_d  = !mv_ready_i && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign advance_d = mv_ready_i || expire_d;
`else
    assign advance_d = mv_ready_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            idx_q         <= 2'd0;
            acc_q         <= 12'd0;
            freq_q        <= '0;
            pw_q          <= '0;
            wave_q        <= '0;
            sync_q        <= '0;
            ring_q        <= '0;
            en_q          <= '0;
            mv_start_o    <= 1'b0;
            mv_voice_o    <= 2'd0;
            mv_freq_o     <= 16'd0;
            mv_pw_o       <= 12'd0;
            mv_wave_sel_o <= 4'd0;
            mv_sync_o     <= 1'b0;
            mv_ring_o     <= 1'b0;
            mix_o         <= 12'd0;
            mix_valid_o   <= 1'b0;
            busy_o        <= 1'b0;
`ifdef VSEQ_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_o     <= 1'b0;
`endif
        end else begin
            mv_start_o  <= 1'b0;
            mix_valid_o <= 1'b0;
`ifdef VSEQ_TIMEOUT_EN
            timeout_o   <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (sample_tick_i) begin
                        freq_q        <= freq_words_i[16*NUM_VOICES-1:16];
                        pw_q          <= pw_words_i[12*NUM_VOICES-1:12];
                        wave_q        <= wave_sels_i[4*NUM_VOICES-1:4];
                        sync_q        <= sync_i[NUM_VOICES-1:1];
                        ring_q        <= ring_mod_i[NUM_VOICES-1:1];
                        en_q          <= voice_en_i;
                        idx_q         <= 2'd0;
                        acc_q         <= 12'd0;
                        mv_voice_o    <= 2'd0;
                        mv_freq_o     <= freq_words_i[15:0];
                        mv_pw_o       <= pw_words_i[11:0];
                        mv_wave_sel_o <= wave_sels_i[3:0];
                        mv_sync_o     <= sync_i[0];
                        mv_ring_o     <= ring_mod_i[0];
                        mv_start_o    <= 1'b1;
                        busy_o        <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef VSEQ_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (advance_d) begin
`ifdef VSEQ_TIMEOUT_EN
                        timeout_o <= expire_d;
`endif
                        // The last voice folds straight into mix_o so the
                        // valid pulse lines up with the DONE cycle.
                        if (idx_q == LAST_VOICE) begin
                            mix_o       <= acc_q + contrib_d;
                            mix_valid_o <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            acc_q         <= acc_q + contrib_d;
                            idx_q         <= nidx_d;
                            mv_voice_o    <= nidx_d;
                            mv_freq_o     <= freq_q[16*nidx_d +: 16];
                            mv_pw_o       <= pw_q[12*nidx_d +: 12];
                            mv_wave_sel_o <= wave_q[4*nidx_d +: 4];
                            mv_sync_o     <= sync_q[nidx_d];
                            mv_ring_o     <= ring_q[nidx_d];
                            mv_start_o    <= 1'b1;
                            state_q       <= S_ISSUE;
                        end
                    end
`ifdef VSEQ_TIMEOUT_EN
                    else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
